// File: rtl/mem_port_arbiter_pkg.sv
// Shared CPU package: arbiter state encoding, port-owner encoding and access size codes.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and load/store ports onto one memory port, one transaction at a time,
// with data priority bounded by a starvation limit for instruction fetch.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cancel,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  arb_state_t  state_reg, state_next;
  owner_t      owner_reg;
  logic        wr_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic [2:0]  starve_cnt_reg;
  logic        drop_reg;
  logic [31:0] inst_rdata_reg, data_rdata_reg;
  logic        grant_inst, grant_data, cancel_hit;

  always_comb begin
    state_next = state_reg;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    case (state_reg)
      IDLE: begin
        if (inst_req && (!data_req || starve_cnt_reg == STARVE_MAX)) grant_inst = 1'b1;
        else if (data_req) grant_data = 1'b1;
        if (grant_inst || grant_data) state_next = ADDR;
      end
      ADDR:    if (m_addr_ok) state_next = DATA;
      DATA:    if (m_data_ok) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A cancel counts from the inst grant cycle until the response cycle of that fetch.
  assign cancel_hit = inst_cancel && (grant_inst || (state_reg != IDLE && owner_reg == OWN_INST));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_INST;
      wr_reg         <= 1'b0;
      size_reg       <= 2'd0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      starve_cnt_reg <= '0;
      drop_reg       <= 1'b0;
      inst_rdata_reg <= '0;
      data_rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (grant_inst || grant_data) begin
        owner_reg <= grant_inst ? OWN_INST : OWN_DATA;
        wr_reg    <= grant_data ? data_wr : 1'b0;
        size_reg  <= grant_data ? data_size : SIZE_WORD;
        addr_reg  <= grant_data ? data_addr : inst_addr;
        wdata_reg <= grant_data ? data_wdata : '0;
      end
      if (grant_inst || !inst_req) starve_cnt_reg <= '0;
      else if (grant_data && starve_cnt_reg != STARVE_MAX) starve_cnt_reg <= starve_cnt_reg + 3'd1;
      if (state_reg == RESP) drop_reg <= 1'b0;
      else if (cancel_hit) drop_reg <= 1'b1;
      // A dropped fetch still consumes m_data_ok but leaves inst_rdata untouched.
      if (state_reg == DATA && m_data_ok) begin
        if (owner_reg == OWN_DATA) data_rdata_reg <= m_rdata;
        else if (!(drop_reg || inst_cancel)) inst_rdata_reg <= m_rdata;
      end
    end
  end

  assign inst_addr_ok = resetn & grant_inst;
  assign data_addr_ok = resetn & grant_data;
  assign inst_data_ok = (state_reg == RESP) && (owner_reg == OWN_INST) && !drop_reg && !inst_cancel;
  assign data_data_ok = (state_reg == RESP) && (owner_reg == OWN_DATA);
  assign inst_rdata   = inst_rdata_reg;
  assign data_rdata   = data_rdata_reg;
  assign m_req        = (state_reg == ADDR);
  assign m_wr         = wr_reg;
  assign m_size       = size_reg;
  assign m_addr       = addr_reg;
  assign m_wdata      = wdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model and a configurable-latency memory responder.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_cancel, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int errors = 0;
  int checks = 0;

  int addr_wait = 0;
  int data_wait = 0;
  bit rand_waits = 1'b0;
  bit mem_acc = 1'b0;
  bit mem_done = 1'b0;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC00000) return 32'h3C1D0001;
    return {a[15:0], a[31:16]} ^ 32'h13579BDF;
  endfunction

  // Memory responder: decides handshakes at the falling edge, DUT samples them on the rising edge.
  initial begin : responder
    bit pend;
    int wcnt;
    logic [31:0] pend_rdata;
    pend = 1'b0; wcnt = 0; pend_rdata = '0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
    forever begin
      @(negedge clk);
      m_addr_ok = 1'b0; m_data_ok = 1'b0; mem_acc = 1'b0; mem_done = 1'b0;
      if (!resetn) begin
        pend = 1'b0; wcnt = 0;
      end else if (pend) begin
        if (wcnt >= data_wait) begin
          m_data_ok = 1'b1; m_rdata = pend_rdata; mem_done = 1'b1; pend = 1'b0; wcnt = 0;
        end else wcnt++;
      end else if (m_req) begin
        if (wcnt >= addr_wait) begin
          m_addr_ok = 1'b1; mem_acc = 1'b1; pend = 1'b1; pend_rdata = mem_word(m_addr); wcnt = 0;
          if (rand_waits) begin
            addr_wait = $urandom_range(0, 2);
            data_wait = $urandom_range(0, 2);
          end
        end else wcnt++;
      end
    end
  end

  task automatic test_reset();
    resetn = 1'b0; inst_req = 1'b1; data_req = 1'b1; inst_cancel = 1'b0;
    inst_addr = 32'h100; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h200; data_wdata = 32'h1;
    #1;
    checks++;
    if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, m_req} !== 5'b0)
      begin errors++; $display("FAIL reset_ok_outputs got=%b exp=00000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, m_req}); end
    @(negedge clk); #1;
    checks++;
    if ({m_wr, m_size, m_addr, m_wdata, inst_rdata, data_rdata} !== '0)
      begin errors++; $display("FAIL reset_values got addr=%h wdata=%h irdata=%h drdata=%h exp all zero", m_addr, m_wdata, inst_rdata, data_rdata); end
    inst_req = 1'b0; data_req = 1'b0;
    #1 resetn = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({m_req, inst_addr_ok, data_addr_ok} !== 3'b0)
      begin errors++; $display("FAIL reset_release_idle got=%b exp=000", {m_req, inst_addr_ok, data_addr_ok}); end
  endtask

  task automatic test_inst_fetch();
    @(negedge clk); inst_req = 1'b1; inst_addr = 32'hBFC00000; #1;
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b10)
      begin errors++; $display("FAIL s1_grant got=%b exp=10", {inst_addr_ok, data_addr_ok}); end
    @(negedge clk); #1;
    checks++;
    if ({m_req, m_wr, m_size, m_addr, inst_addr_ok} !== {1'b1, 1'b0, SIZE_WORD, 32'hBFC00000, 1'b0})
      begin errors++; $display("FAIL s1_mport got req=%b wr=%b size=%0d addr=%h aok=%b exp 1 0 2 bfc00000 0", m_req, m_wr, m_size, m_addr, inst_addr_ok); end
    @(negedge clk); inst_req = 1'b0; #1;
    checks++;
    if ({m_req, inst_data_ok} !== 2'b00)
      begin errors++; $display("FAIL s1_cycle2 got req=%b dok=%b exp 0 0", m_req, inst_data_ok); end
    @(negedge clk); #1;
    checks++;
    if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h3C1D0001)
      begin errors++; $display("FAIL s1_resp got dok=%b rdata=%h exp 1 3c1d0001", inst_data_ok, inst_rdata); end
    @(negedge clk); #1;
    checks++;
    if (inst_data_ok !== 1'b0 || inst_rdata !== 32'h3C1D0001)
      begin errors++; $display("FAIL s1_hold got dok=%b rdata=%h exp 0 3c1d0001", inst_data_ok, inst_rdata); end
  endtask

  task automatic test_priority();
    int got = -1;
    bit dok3 = 1'b0;
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'hBFC00004;
    data_req = 1'b1; data_wr = 1'b1; data_size = SIZE_WORD; data_addr = 32'h80001000; data_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b01)
      begin errors++; $display("FAIL s2_data_first got=%b exp=01", {inst_addr_ok, data_addr_ok}); end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) data_req = 1'b0;
      #1;
      if (k == 1) begin
        checks++;
        if ({m_req, m_wr, m_size, m_addr, m_wdata} !== {1'b1, 1'b1, SIZE_WORD, 32'h80001000, 32'hDEADBEEF})
          begin errors++; $display("FAIL s2_store_bundle got req=%b wr=%b size=%0d addr=%h wdata=%h", m_req, m_wr, m_size, m_addr, m_wdata); end
      end
      if (k == 3) dok3 = data_data_ok;
      if (inst_addr_ok) begin got = k; break; end
    end
    checks++;
    if (!dok3) begin errors++; $display("FAIL s2_store_done got data_data_ok=0 at cycle 3 exp 1"); end
    checks++;
    if (got != 4) begin errors++; $display("FAIL s2_inst_next got grant cycle=%0d exp 4", got); end
    @(negedge clk); inst_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_starvation();
    int ngrants = 0;
    bit got_inst = 1'b0;
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h00001000;
    data_req = 1'b1; data_wr = 1'b0; data_size = SIZE_WORD; data_addr = 32'h00002000;
    for (int k = 0; k < 80; k++) begin
      #1;
      if (inst_addr_ok) begin got_inst = 1'b1; break; end
      if (data_addr_ok) ngrants++;
      @(negedge clk);
      data_addr = data_addr + 32'd4;
    end
    checks++;
    if (!got_inst) begin errors++; $display("FAIL s3_timeout got no inst grant in 80 cycles exp grant"); end
    checks++;
    if (ngrants != STARVE_LIMIT) begin errors++; $display("FAIL s3_data_grants got=%0d exp=%0d", ngrants, STARVE_LIMIT); end
    @(negedge clk); inst_req = 1'b0; data_req = 1'b0; #1;
    checks++;
    if (m_req !== 1'b1 || m_addr !== 32'h00001000)
      begin errors++; $display("FAIL s3_inst_addr got req=%b addr=%h exp 1 00001000", m_req, m_addr); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_cancel();
    @(negedge clk); inst_req = 1'b1; inst_addr = 32'hBFC00010;
    @(negedge clk); inst_req = 1'b0;
    @(negedge clk); inst_cancel = 1'b1;
    @(negedge clk); inst_cancel = 1'b0; #1;
    checks++;
    if ({inst_data_ok, m_req} !== 2'b00)
      begin errors++; $display("FAIL s4_dropped got dok=%b req=%b exp 0 0", inst_data_ok, m_req); end
    @(negedge clk); inst_req = 1'b1; inst_addr = 32'hBFC00020; #1;
    checks++;
    if ({inst_data_ok, inst_addr_ok} !== 2'b01)
      begin errors++; $display("FAIL s4_next_grant got dok=%b aok=%b exp 0 1", inst_data_ok, inst_addr_ok); end
    @(negedge clk); inst_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (inst_data_ok !== 1'b1 || inst_rdata !== mem_word(32'hBFC00020))
      begin errors++; $display("FAIL s4_next_resp got dok=%b rdata=%h exp 1 %h", inst_data_ok, inst_rdata, mem_word(32'hBFC00020)); end
    // cancel held through a data-owned transaction must not disturb it
    @(negedge clk); data_req = 1'b1; data_wr = 1'b0; data_size = SIZE_BYTE; data_addr = 32'h00003000; inst_cancel = 1'b1;
    @(negedge clk); data_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== mem_word(32'h00003000))
      begin errors++; $display("FAIL s4_data_ignores_cancel got dok=%b rdata=%h exp 1 %h", data_data_ok, data_rdata, mem_word(32'h00003000)); end
    @(negedge clk); inst_cancel = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wait_states();
    int pulses = 0;
    int pulse_cycle = -1;
    addr_wait = 3;
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b1; data_size = SIZE_HALF; data_addr = 32'h80002002; data_wdata = 32'h0000BEEF;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) data_req = 1'b0;
      #1;
      if (c <= 4) begin
        checks++;
        if ({m_req, m_wr, m_size, m_addr, m_wdata} !== {1'b1, 1'b1, SIZE_HALF, 32'h80002002, 32'h0000BEEF})
          begin errors++; $display("FAIL s5_stable_c%0d got req=%b wr=%b size=%0d addr=%h wdata=%h", c, m_req, m_wr, m_size, m_addr, m_wdata); end
      end
      if (c == 5) begin
        checks++;
        if (m_req !== 1'b0) begin errors++; $display("FAIL s5_req_drop got req=%b exp 0", m_req); end
      end
      if (data_data_ok) begin pulses++; pulse_cycle = c; end
    end
    addr_wait = 0;
    checks++;
    if (pulses != 1 || pulse_cycle != 6)
      begin errors++; $display("FAIL s5_one_pulse got pulses=%0d at cycle %0d exp 1 at 6", pulses, pulse_cycle); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    data_wait = 5;
    @(negedge clk); data_req = 1'b1; data_wr = 1'b0; data_size = SIZE_WORD; data_addr = 32'h00004000;
    @(negedge clk); data_req = 1'b0;
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({m_req, m_wr, m_size, m_addr, m_wdata, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, inst_rdata, data_rdata} !== '0)
      begin errors++; $display("FAIL s6_async_clear got req=%b addr=%h irdata=%h drdata=%h exp all zero", m_req, m_addr, inst_rdata, data_rdata); end
    @(negedge clk);
    #2 resetn = 1'b1; data_wait = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (inst_data_ok || data_data_ok || m_req) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL s6_no_resp got activity cycles=%0d exp 0", pulses); end
  endtask

  task automatic test_random();
    bit busy = 0, own_i = 0, drop = 0, accepted = 0, resp_due = 0, clr_i = 0, clr_d = 0;
    bit exp_gi, exp_gd, exp_ido, exp_ddo;
    int cnt = 0;
    logic        cur_wr = 1'b0;
    logic [1:0]  cur_size = 2'd0;
    logic [31:0] cur_addr = '0, cur_wdata = '0;
    rand_waits = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (clr_i) inst_req = 1'b0;
      if (clr_d) data_req = 1'b0;
      clr_i = 0; clr_d = 0;
      if (!inst_req && $urandom_range(0, 2) == 0) begin inst_req = 1'b1; inst_addr = $urandom & 32'hFFFFFFFC; end
      if (!data_req && $urandom_range(0, 1) == 0) begin
        data_req = 1'b1; data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 2));
        data_addr = $urandom; data_wdata = $urandom;
      end
      inst_cancel = ($urandom_range(0, 11) == 0);
      #1;
      exp_gi = !busy && inst_req && (!data_req || cnt == STARVE_LIMIT);
      exp_gd = !busy && data_req && !exp_gi;
      checks++;
      if ({inst_addr_ok, data_addr_ok} !== {exp_gi, exp_gd})
        begin errors++; $display("FAIL rnd_grant n=%0d got=%b%b exp=%b%b", n, inst_addr_ok, data_addr_ok, exp_gi, exp_gd); end
      checks++;
      if (busy && !accepted) begin
        if (m_req !== 1'b1 || m_addr !== cur_addr || m_wr !== cur_wr || m_size !== cur_size || (!own_i && m_wdata !== cur_wdata))
          begin errors++; $display("FAIL rnd_mport n=%0d got req=%b addr=%h wr=%b size=%0d exp 1 %h %b %0d", n, m_req, m_addr, m_wr, m_size, cur_addr, cur_wr, cur_size); end
      end else if (m_req !== 1'b0)
        begin errors++; $display("FAIL rnd_mport_idle n=%0d got req=%b exp 0", n, m_req); end
      exp_ido = resp_due && own_i && !drop && !inst_cancel;
      exp_ddo = resp_due && !own_i;
      checks++;
      if ({inst_data_ok, data_data_ok} !== {exp_ido, exp_ddo})
        begin errors++; $display("FAIL rnd_dataok n=%0d got=%b%b exp=%b%b", n, inst_data_ok, data_data_ok, exp_ido, exp_ddo); end
      if (exp_ido) begin
        checks++;
        if (inst_rdata !== mem_word(cur_addr)) begin errors++; $display("FAIL rnd_irdata n=%0d got=%h exp=%h", n, inst_rdata, mem_word(cur_addr)); end
      end
      if (exp_ddo) begin
        checks++;
        if (data_rdata !== mem_word(cur_addr)) begin errors++; $display("FAIL rnd_drdata n=%0d got=%h exp=%h", n, data_rdata, mem_word(cur_addr)); end
      end
      // advance the transaction-level model across the coming rising edge
      if (resp_due) begin busy = 0; resp_due = 0; end
      if (mem_done) resp_due = 1;
      if (mem_acc) accepted = 1;
      if (busy && own_i && inst_cancel) drop = 1;
      if (exp_gi || exp_gd) begin
        busy = 1; accepted = 0; own_i = exp_gi; drop = exp_gi && inst_cancel;
        cur_wr = exp_gd ? data_wr : 1'b0;
        cur_size = exp_gd ? data_size : SIZE_WORD;
        cur_addr = exp_gd ? data_addr : inst_addr;
        cur_wdata = data_wdata;
        clr_i = exp_gi; clr_d = exp_gd;
      end
      if (exp_gi || !inst_req) cnt = 0;
      else if (exp_gd && cnt < STARVE_LIMIT) cnt++;
    end
    rand_waits = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog got no completion by 500us exp completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin : main
    test_reset();
    test_inst_fetch();
    test_priority();
    test_starvation();
    test_cancel();
    test_wait_states();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
